// File: rtl/pktgen_pkg.sv
// Shared definitions for the AXI-Stream packet generator: mux target codes,
// FSM encoding and LFSR constants used when PKTGEN_LFSR_EN is defined.
package pktgen_pkg;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_M1   = 3'd1;
  localparam logic [2:0] SEL_M2   = 3'd2;
  localparam logic [2:0] SEL_S1   = 3'd3;
  localparam logic [2:0] SEL_S2   = 3'd4;
  localparam logic [2:0] SEL_S3   = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  // Feedback taps x^8+x^6+x^5+x^4+1 -> state bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS      = 8'hB8;
  localparam logic [7:0] LFSR_ZERO_SEED = 8'h01;

  function automatic logic sel_is_target(input logic [2:0] s);
    return (s >= SEL_M1) && (s <= SEL_S3);
  endfunction

endpackage

// File: rtl/pktgen_pattern.sv
// Combinational next-beat data generator: increment by default, 8-bit
// Fibonacci LFSR when PKTGEN_LFSR_EN is defined.
module pktgen_pattern #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] cur,
  output logic [DATA_W-1:0] nxt
);

`ifdef PKTGEN_LFSR_EN
  import pktgen_pkg::*;

  // Only the low byte carries the LFSR; wider buses see zeros above it.
  always_comb begin
    nxt      = '0;
    nxt[7:0] = {cur[6:0], ^(cur[7:0] & LFSR_TAPS)};
  end
`else
  assign nxt = cur + DATA_W'(1);
`endif

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet source driving the 5-way target mux select and stream.
// Define PKTGEN_LFSR_EN to switch the data pattern from increment to LFSR.
module axis_pkt_gen
  import pktgen_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 8,
  parameter int ARM_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_sel,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_seed,
  output logic [2:0]        sel,
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  output logic              tlast,
  input  logic              tready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  beat_cnt
);

  localparam logic [3:0] ARM_LAST = 4'(ARM_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [3:0]        arm_cnt_q, arm_cnt_d;

  logic              cmd_fire;
  logic              cmd_bad;
  logic              beat_fire;
  logic [LEN_W-1:0]  beat_cnt_inc;
  logic [DATA_W-1:0] tdata_nxt;
  logic [DATA_W-1:0] first_beat;

  assign cmd_fire     = cmd_valid & cmd_ready_q;
  assign cmd_bad      = !sel_is_target(cmd_sel) || (cmd_len == '0);
  assign beat_fire    = tvalid_q & tready;
  assign beat_cnt_inc = beat_cnt_q + LEN_W'(1);

  pktgen_pattern #(
    .DATA_W (DATA_W)
  ) u_pattern (
    .cur (tdata_q),
    .nxt (tdata_nxt)
  );

`ifdef PKTGEN_LFSR_EN
  // An all-zero LFSR state would lock up, so it is replaced at load time.
  assign first_beat = (seed_q == '0) ? DATA_W'(LFSR_ZERO_SEED) : seed_q;
`else
  assign first_beat = seed_q;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    seed_d     = seed_q;
    arm_cnt_d  = arm_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          len_d  = cmd_len;
          seed_d = cmd_seed;
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            sel_d      = cmd_sel;
            beat_cnt_d = '0;
            arm_cnt_d  = '0;
            state_d    = ARM;
          end
        end
      end

      ARM: begin
        if (arm_cnt_q == ARM_LAST) begin
          state_d  = SEND;
          tvalid_d = 1'b1;
          tdata_d  = first_beat;
          tlast_d  = (len_q == LEN_W'(1));
        end else begin
          arm_cnt_d = arm_cnt_q + 4'd1;
        end
      end

      SEND: begin
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_inc;
          tdata_d    = tdata_nxt;
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            // The beat now being presented is the last one when the count
            // of accepted beats reaches len-1.
            tlast_d = (beat_cnt_inc == len_q - LEN_W'(1));
          end
        end
      end

      DONE: begin
        sel_d   = SEL_NONE;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d == ARM) || (state_d == SEND);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= SEL_NONE;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      beat_cnt_q  <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      arm_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      beat_cnt_q  <= beat_cnt_d;
      len_q       <= len_d;
      seed_q      <= seed_d;
      arm_cnt_q   <= arm_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign sel       = sel_q;
  assign tdata     = tdata_q;
  assign tvalid    = tvalid_q;
  assign tlast     = tlast_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: vector table, hand-written corner
// sequences and randomized commands against a beat-list reference model.
module tb_axis_pkt_gen;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;
  localparam int ARM_C  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_sel = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_seed = '0;
  logic [2:0]        sel;
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready = 1'b0;
  logic              busy;
  logic              done;
  logic              err;
  logic [LEN_W-1:0]  beat_cnt;

  axis_pkt_gen #(
    .DATA_W     (DATA_W),
    .LEN_W      (LEN_W),
    .ARM_CYCLES (ARM_C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_len   (cmd_len),
    .cmd_seed  (cmd_seed),
    .sel       (sel),
    .tdata     (tdata),
    .tvalid    (tvalid),
    .tlast     (tlast),
    .tready    (tready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference model: beat i of a packet is derived from the seed alone.
  function automatic logic [DATA_W-1:0] model_beat(input logic [DATA_W-1:0] seed, input int i);
`ifdef PKTGEN_LFSR_EN
    logic [7:0] v;
    v = (seed == 8'h00) ? 8'h01 : seed;
    for (int k = 0; k < i; k++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
`else
    return DATA_W'((int'(seed) + i) % (1 << DATA_W));
`endif
  endfunction

  function automatic bit model_reject(input logic [2:0] s, input int len);
    return (s < 3'd1) || (s > 3'd5) || (len == 0);
  endfunction

  // Monitor: handshakes, pulse counts, stall stability, sel stability.
  logic [DATA_W:0]   beats[$];
  int                done_seen = 0;
  int                err_seen = 0;
  logic              p_rst = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_busy = 1'b0;
  logic [DATA_W-1:0] p_data = '0;
  logic [2:0]        p_sel = '0;

  always @(posedge clk) begin
    if (p_rst && p_valid && !p_ready)
      check("stall_hold", {tvalid, tlast, tdata}, {1'b1, p_last, p_data});
    if (p_rst && p_busy && busy)
      check("sel_stable", sel, p_sel);
    if (rst_n && tvalid && tready) beats.push_back({tlast, tdata});
    if (rst_n && done) done_seen++;
    if (rst_n && err) err_seen++;
    p_rst   = rst_n;
    p_valid = tvalid;
    p_ready = tready;
    p_last  = tlast;
    p_data  = tdata;
    p_busy  = busy;
    p_sel   = sel;
  end

  // mode 0: tready=1; mode 1: two stall cycles on beat 2; mode 2: random tready.
  task automatic run_cmd(input logic [2:0] s, input int len, input logic [DATA_W-1:0] seed,
                         input int mode, output int errs, output logic [DATA_W-1:0] last_data);
    bit bad;
    int e0, d0, cyc, first_v, stall;
    bad = model_reject(s, len);
    e0 = err_seen;
    d0 = done_seen;
    first_v = -1;
    stall = 0;
    last_data = '0;
    beats.delete();
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_sel   = s;
    cmd_len   = LEN_W'(len);
    cmd_seed  = seed;
    tready    = (mode == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (bad) begin
      check("err_pulse", err, 1);
      check("err_sel", sel, 0);
      check("err_cmd_ready", cmd_ready, 1);
      check("err_busy", busy, 0);
      check("err_tvalid", tvalid, 0);
      @(posedge clk); #1;
      check("err_one_cycle", err, 0);
      check("err_count", err_seen - e0, 1);
      check("err_no_beats", beats.size(), 0);
      check("err_no_done", done_seen - d0, 0);
      errs = err_seen - e0;
      $display("txn sel=%0d len=%0d seed=%02h rejected", s, len, seed);
      return;
    end
    check("sel_after_accept", sel, s);
    check("busy_after_accept", busy, 1);
    check("arm_tvalid", tvalid, 0);
    check("arm_cmd_ready", cmd_ready, 0);
    cyc = 0;
    while (!done && cyc < 4000) begin
      if (tvalid && first_v < 0) first_v = cyc;
      case (mode)
        0: tready = 1'b1;
        1: begin
          tready = !(beats.size() == 1 && stall < 2);
          if (tvalid && !tready) stall++;
        end
        default: tready = ($urandom_range(0, 3) != 0);
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    check("done_reached", done, 1);
    check("done_cmd_ready", cmd_ready, 0);
    check("done_busy", busy, 0);
    check("done_tvalid", tvalid, 0);
    check("first_tvalid_latency", first_v, ARM_C);
    if (mode == 0) check("packet_cycles", cyc, ARM_C + len);
    check("handshakes", beats.size(), len);
    for (int i = 0; i < len && i < beats.size(); i++) begin
      check("beat_data", beats[i][DATA_W-1:0], model_beat(seed, i));
      check("beat_tlast", beats[i][DATA_W], (i == len - 1));
    end
    if (beats.size() > 0) last_data = beats[beats.size()-1][DATA_W-1:0];
    check("beat_cnt_done", beat_cnt, len);
    tready = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("sel_released", sel, 0);
    check("cmd_ready_back", cmd_ready, 1);
    check("beat_cnt_hold", beat_cnt, len);
    check("done_count", done_seen - d0, 1);
    errs = err_seen - e0;
    $display("txn sel=%0d len=%0d seed=%02h mode=%0d beats=%0d cycles=%0d", s, len, seed, mode,
             beats.size(), cyc);
  endtask

  typedef struct {
    logic [2:0]        sel;
    int                len;
    logic [DATA_W-1:0] seed;
    int                mode;
    int                exp_err;
    logic [DATA_W-1:0] exp_last;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs, n;
    logic [DATA_W-1:0] last;

    vecs[0] = '{3'd3, 4,   8'h10, 0, 0, 8'h13};
    vecs[1] = '{3'd1, 3,   8'hFE, 1, 0, 8'h00};
    vecs[2] = '{3'd6, 5,   8'h00, 0, 1, 8'h00};
    vecs[3] = '{3'd2, 0,   8'h55, 0, 1, 8'h00};
    vecs[4] = '{3'd5, 1,   8'hAA, 0, 0, 8'hAA};
    vecs[5] = '{3'd0, 2,   8'h01, 0, 1, 8'h00};
    vecs[6] = '{3'd7, 1,   8'h02, 0, 1, 8'h00};
    vecs[7] = '{3'd4, 255, 8'h80, 2, 0, 8'h7E};
    vecs[8] = '{3'd2, 6,   8'hFC, 2, 0, 8'h01};

    // Reset, with a command offered to show it is ignored.
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_sel = 3'd3;
    cmd_len = 8'd4;
    tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {cmd_ready, busy, done, err, tvalid, tlast}, 0);
    check("rst_sel", sel, 0);
    check("rst_tdata", tdata, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    cmd_valid = 1'b0;
    tready = 1'b0;
    rst_n = 1'b1;
    check("cmd_ready_before_edge", cmd_ready, 0);
    @(posedge clk); #1;
    check("cmd_ready_after_release", cmd_ready, 1);
    $display("txn reset released");

    for (int v = 0; v < 9; v++) begin
      run_cmd(vecs[v].sel, vecs[v].len, vecs[v].seed, vecs[v].mode, errs, last);
      check("vec_err", errs, vecs[v].exp_err);
`ifndef PKTGEN_LFSR_EN
      if (vecs[v].exp_err == 0) check("vec_last_beat", last, vecs[v].exp_last);
`endif
    end

    // Reset during beat 3 of an 8-beat packet.
    begin
      int d0;
      d0 = done_seen;
      beats.delete();
      cmd_valid = 1'b1;
      cmd_sel = 3'd4;
      cmd_len = 8'd8;
      cmd_seed = 8'h20;
      tready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = 0;
      while (beats.size() < 2 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check("rst_mid_wait", beats.size(), 2);
      check("rst_mid_beat3", tdata, model_beat(8'h20, 2));
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_tvalid", tvalid, 0);
      check("rst_mid_sel", sel, 0);
      check("rst_mid_flags", {busy, done, tlast, cmd_ready}, 0);
      check("rst_mid_beat_cnt", beat_cnt, 0);
      rst_n = 1'b1;
      tready = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_cmd_ready", cmd_ready, 1);
      check("rst_mid_no_done", done_seen - d0, 0);
      check("rst_mid_no_extra_beat", beats.size(), 2);
      $display("txn reset during packet sel=4 len=8");
      run_cmd(3'd2, 3, 8'h40, 0, errs, last);
    end

    // Randomized commands against the model.
    for (int r = 0; r < 25; r++) begin
      logic [2:0] rs;
      int rl;
      logic [DATA_W-1:0] rd;
      rs = 3'($urandom_range(0, 7));
      rl = $urandom_range(0, 12);
      rd = DATA_W'($urandom());
      run_cmd(rs, rl, rd, $urandom_range(0, 2), errs, last);
      check("rand_err", errs, model_reject(rs, rl) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
